addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Shares one W-bit add/subtract datapath between NREQ requesters: round-robin arbitration, a two-stage registered pipeline, and a tagged response port with backpressure. Sits between the operand sources (controllers, test sequencers) and the add/sub arithmetic. Issue rate is one operation per cycle; results return in issue order.

## Interface
- NREQ, default 4: number of requesters; must be at least 2.
- W, default 4: operand and result width.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit is high.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- req_m  in  NREQ  mode: 1 = add, 0 = subtract.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  $clog2(NREQ)  index of the requester that issued the operation.
- rsp_sum  out  W  result.
- rsp_c_out  out  1  carry out of the MSB.

## Operation
- **Arithmetic**
  - Add: {c_out, sum} = a + b.
  - Subtract: {c_out, sum} = a + ~b + 1.
  - c_out = 1 on subtract means no borrow (a >= b unsigned).
  - Result is modulo 2^W.
- **Arbitration**
  - Round-robin with pointer ptr; ptr resets to 0.
  - Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … NREQ-1, 0, … (wraps).
  - Grant is combinational from req_valid and ptr only; it never depends on req_ready.
- **Handshake**
  - req_ready[i] = grant[i] & s1_adv.
  - An operation is accepted when req_valid[i] & req_ready[i].
  - On accept: ptr <= (i+1) mod NREQ. Without an accept, ptr holds.
  - A requester must hold valid and operands stable until accepted. Deasserting valid before accept is permitted and drops that request with no side effect.
- **Pipeline**
  - Stage 1 registers {a, b, m, id}.
  - Stage 2 registers {sum, c_out, id}, computed from stage 1.
  - s2_adv = !s2_v | rsp_ready.
  - s1_adv = !s1_v | s2_adv.
  - Stage 2 loads from stage 1 when s2_adv; s2_v <= s1_v.
  - Stage 1 loads the accepted request when s1_adv; s1_v <= accept.
- **Response**
  - rsp_valid = s2_v; rsp_* are driven directly from stage-2 registers.
  - While rsp_valid & !rsp_ready, all rsp_* outputs hold stable.
- **Reset**
  - s1_v, s2_v, ptr, rsp_sum, rsp_c_out and rsp_id all go to 0.
  - req_ready is all-zero while rst is high.
  - Reset mid-operation discards all in-flight results; nothing is emitted afterwards for them.

## Timing
- Latency: accept at edge k; rsp_valid is high after edge k+1 (two registers, request to response).
- Throughput: one accept per cycle while rsp_ready is held high.
- **Full stall**: both stages valid and rsp_ready=0 gives req_ready all-zero and ptr frozen.
- **Stall release**: the first cycle with rsp_ready=1 re-enables req_ready in that same cycle (combinational path rsp_ready -> req_ready).
- **Simultaneous drain and fill**: accept, stage advance and response handshake in the same cycle lose nothing.
- **Single requester**: repeated requests from one requester are accepted back-to-back every cycle.

## Configuration
- Macro: ADDSUB_ARB_OVF_EN.
- **Defined**:
  - Adds output port rsp_ovf (1 bit), carried in stage 2 and reset to 0.
  - rsp_ovf is two's-complement signed overflow: (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]), where b' = b for add and ~b for subtract.
- **Undefined**: no rsp_ovf port and no associated logic.

## Structure
- **Package addsub_arb_pkg**:
  - MODE_ADD = 1'b1, MODE_SUB = 1'b0.
  - Default widths.
  - id-width helper function.
  - Stage-1 and stage-2 packed struct typedefs.
- **Sub-module addsub_unit**, parameter W:
  - Purely combinational.
  - Inputs a, b, m; outputs sum, c_out, and ovf (ovf only under the macro).
  - Instantiated once, between stage 1 and stage 2.

## Test plan
- Reset, then req0 issues a=2, b=3, m=1 -> two cycles later rsp_valid=1, id=0, sum=5, c_out=0.
- Subtract cases:
  - a=4, b=7, m=0 -> sum=13, c_out=0.
  - a=7, b=7, m=0 -> sum=0, c_out=1.
  - a=1, b=14, m=0 -> sum=3, c_out=0.
- All four requesters valid continuously from reset -> accepts in order 0,1,2,3,0…, one per cycle; rsp_id follows the same order.
- Backpressure: stream from req2 with rsp_ready=0 for 5 cycles -> exactly two accepts, then req_ready=0 and rsp outputs frozen; on release, results arrive in order with none lost or duplicated.
- rst asserted with both stages valid -> next cycle rsp_valid=0, ptr=0; no stale response appears afterwards.
- Under ADDSUB_ARB_OVF_EN:
  - a=7, b=1, m=1 -> sum=8, rsp_ovf=1.
  - a=0, b=15, m=1 -> sum=15, rsp_ovf=0.

Source files
------------

// File: rtl/addsub_arb_pkg.sv
// Shared constants, widths and stage bundle shapes for addsub_arbiter.
// Optional signed-overflow output is enabled by ADDSUB_ARB_OVF_EN.
package addsub_arb_pkg;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_DEF = id_w(NREQ_DEF);

  typedef struct packed {
    logic              v;
    logic [ID_DEF-1:0] id;
    logic              m;
    logic [W_DEF-1:0]  a;
    logic [W_DEF-1:0]  b;
  } s1_t;

  typedef struct packed {
    logic              v;
    logic [ID_DEF-1:0] id;
`ifdef ADDSUB_ARB_OVF_EN
    logic              ovf;
`endif
    logic              c_out;
    logic [W_DEF-1:0]  sum;
  } s2_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational W-bit add/subtract with carry-out.
// ADDSUB_ARB_OVF_EN adds a signed-overflow output.
module addsub_unit
  import addsub_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] sum,
`ifdef ADDSUB_ARB_OVF_EN
  output logic         ovf,
`endif
  output logic         c_out
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  always_comb begin
    b_eff = (m == MODE_ADD) ? b : ~b;
    full  = {1'b0, a} + {1'b0, b_eff}
          + {{W{1'b0}}, (m == MODE_SUB)};
  end

  assign sum   = full[W-1:0];
  assign c_out = full[W];

`ifdef ADDSUB_ARB_OVF_EN
  assign ovf = (a[W-1] == b_eff[W-1])
             & (sum[W-1] != a[W-1]);
`endif

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin shared add/sub with a two-stage pipeline and tagged response.
// ADDSUB_ARB_OVF_EN adds the rsp_ovf output.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*W-1:0]     req_a,
  input  logic [NREQ*W-1:0]     req_b,
  input  logic [NREQ-1:0]       req_m,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [id_w(NREQ)-1:0] rsp_id,
  output logic [W-1:0]          rsp_sum,
`ifdef ADDSUB_ARB_OVF_EN
  output logic                  rsp_ovf,
`endif
  output logic                  rsp_c_out
);

  localparam int IW = id_w(NREQ);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
    logic          m;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
  } stg1_t;

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
`ifdef ADDSUB_ARB_OVF_EN
    logic          ovf;
`endif
    logic          c_out;
    logic [W-1:0]  sum;
  } stg2_t;

  stg1_t s1_q, s1_d;
  stg2_t s2_q, s2_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic            gnt_found;
  logic [IW-1:0]   gnt_id;
  logic [NREQ-1:0] gnt;
  logic            s1_adv, s2_adv;
  logic            rdy_en, accept;

  logic [W-1:0] u_sum;
  logic         u_c;
`ifdef ADDSUB_ARB_OVF_EN
  logic         u_ovf;
`endif

  addsub_unit #(.W(W)) u_alu (
    .a     (s1_q.a),
    .b     (s1_q.b),
    .m     (s1_q.m),
    .sum   (u_sum),
`ifdef ADDSUB_ARB_OVF_EN
    .ovf   (u_ovf),
`endif
    .c_out (u_c)
  );

  // Grant search depends only on req_valid and ptr, never on ready.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt       = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_id    = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
    if (gnt_found) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    s2_adv    = !s2_q.v | rsp_ready;
    s1_adv    = !s1_q.v | s2_adv;
    rdy_en    = s1_adv & !rst;
    req_ready = gnt & {NREQ{rdy_en}};
    accept    = gnt_found & rdy_en;

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    s1_d = s1_q;
    if (s1_adv) begin
      s1_d.v  = accept;
      s1_d.id = gnt_id;
      s1_d.m  = req_m[gnt_id];
      s1_d.a  = req_a[int'(gnt_id)*W +: W];
      s1_d.b  = req_b[int'(gnt_id)*W +: W];
    end

    s2_d = s2_q;
    if (s2_adv) begin
      s2_d.v     = s1_q.v;
      s2_d.id    = s1_q.id;
      s2_d.sum   = u_sum;
      s2_d.c_out = u_c;
`ifdef ADDSUB_ARB_OVF_EN
      s2_d.ovf   = u_ovf;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      ptr_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      ptr_q <= ptr_d;
    end
  end

  assign rsp_valid = s2_q.v;
  assign rsp_id    = s2_q.id;
  assign rsp_sum   = s2_q.sum;
  assign rsp_c_out = s2_q.c_out;
`ifdef ADDSUB_ARB_OVF_EN
  assign rsp_ovf   = s2_q.ovf;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter (NREQ=4, W=4).
// Define ADDSUB_ARB_OVF_EN to exercise rsp_ovf.
module tb_addsub_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_m;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_sum;
  logic        rsp_c_out;
`ifdef ADDSUB_ARB_OVF_EN
  logic        rsp_ovf;
`endif

  addsub_arbiter #(.NREQ(4), .W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
`ifdef ADDSUB_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .rsp_c_out (rsp_c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int sum;
    int c;
    int ovf;
  } exp_t;

  exp_t q[$];
  int   ncmp;
  int   nfail;
  int   m_ptr;
  bit   m_s1v;
  bit   m_s2v;
  int   last_acc;

  function automatic int sx(input int x);
    return (x >= 8) ? x - 16 : x;
  endfunction

  function automatic exp_t model(input int id, input int a,
                                 input int b, input int m);
    exp_t e;
    int   s;
    e.id = id;
    if (m != 0) begin
      e.sum = (a + b) % 16;
      e.c   = (a + b >= 16) ? 1 : 0;
      s     = sx(a) + sx(b);
    end else begin
      e.sum = (a - b + 16) % 16;
      e.c   = (a >= b) ? 1 : 0;
      s     = sx(a) - sx(b);
    end
    e.ovf = (s > 7 || s < -8) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b,
                         input int m);
    req_valid[i]       = 1'b1;
    req_a[i*4 +: 4]    = 4'(a);
    req_b[i*4 +: 4]    = 4'(b);
    req_m[i]           = (m != 0);
  endtask

  // One cycle: check the settled outputs against the model, then advance.
  task automatic tick();
    int         g;
    int         idx;
    bit         s1a;
    bit         s2a;
    logic [3:0] er;
    exp_t       e;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    s2a = !m_s2v || rsp_ready;
    s1a = !m_s1v || s2a;
    er  = '0;
    if (g >= 0 && s1a && !rst) er[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_s2v));
    if (!rst && m_s2v) begin
      if (q.size() == 0) begin
        chk("sb_empty", 32'(rsp_valid), 32'(0));
      end else if (rsp_ready) begin
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), e.id);
        chk("rsp_sum", 32'(rsp_sum), e.sum);
        chk("rsp_c_out", 32'(rsp_c_out), e.c);
`ifdef ADDSUB_ARB_OVF_EN
        chk("rsp_ovf", 32'(rsp_ovf), e.ovf);
`endif
      end else begin
        chk("hold_sum", 32'(rsp_sum), q[0].sum);
        chk("hold_id", 32'(rsp_id), q[0].id);
      end
    end
    last_acc = -1;
    if (rst) begin
      m_ptr = 0;
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      q.delete();
    end else begin
      if (s2a) m_s2v = m_s1v;
      if (s1a) m_s1v = (er != 0);
      if (er != 0) begin
        q.push_back(model(g, int'(req_a[g*4 +: 4]),
                          int'(req_b[g*4 +: 4]), int'(req_m[g])));
        m_ptr    = (g + 1) % 4;
        last_acc = g;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ncmp      = 0;
    nfail     = 0;
    m_ptr     = 0;
    m_s1v     = 1'b0;
    m_s2v     = 1'b0;
    last_acc  = -1;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_m     = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1, 1, 1);
    tick();
    tick();
    req_valid = '0;
    rst       = 1'b0;
    tick();

    // First op: response visible after the second edge.
    set_req(0, 2, 3, 1);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("first_rsp", {28'd0, rsp_valid, rsp_id, rsp_c_out},
        {28'd0, 1'b1, 2'd0, 1'b0});
    chk("first_sum", 32'(rsp_sum), 32'd5);
    drain(2);

    // Subtract cases back-to-back from a single requester.
    set_req(1, 4, 7, 0);
    tick();
    set_req(1, 7, 7, 0);
    tick();
    set_req(1, 1, 14, 0);
    tick();
    drain(3);

    // All four valid: accepts rotate 0,1,2,3,0,...
    for (int i = 0; i < 4; i++) set_req(i, i + 3, 2 * i, i % 2);
    for (int i = 0; i < 9; i++) tick();
    drain(3);

    // Backpressure on a req2 stream.
    rsp_ready = 1'b0;
    set_req(2, 9, 4, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_acc == 2) set_req(2, 3 + i, 10 - i, i % 2);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc == 2) set_req(2, 12 - i, i, 0);
    end
    drain(3);

    // Reset with both stages full.
    rsp_ready = 1'b0;
    set_req(3, 5, 6, 1);
    tick();
    set_req(3, 8, 2, 0);
    tick();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = '0;
    drain(4);

    // Random traffic; held requests keep their operands.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] || last_acc == i) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[i*4 +: 4] = 4'($urandom_range(0, 15));
          req_b[i*4 +: 4] = 4'($urandom_range(0, 15));
          req_m[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(4);

`ifdef ADDSUB_ARB_OVF_EN
    set_req(0, 7, 1, 1);
    tick();
    set_req(0, 0, 15, 1);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("ovf_pos", {28'd0, rsp_ovf, rsp_sum}, {28'd0, 1'b1, 4'd8});
    tick();
    #1;
    chk("ovf_none", {28'd0, rsp_ovf, rsp_sum}, {28'd0, 1'b0, 4'd15});
    drain(3);
`endif

    chk("sb_left", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
